// File: rtl/seg7_if.sv
// Display bus for the 4-digit scanned 7-segment driver: staged hex data and
// live decimal points in, multiplexed digit/segment drive and frame strobe out.
interface seg7_if;
  logic [15:0] data;
  logic        load;
  logic [3:0]  dp_in;
  logic [3:0]  dig_sel;
  logic [7:0]  seg;
  logic        frame_done;

  modport master (output data, load, dp_in, input dig_sel, seg, frame_done);
  modport slave  (input data, load, dp_in, output dig_sel, seg, frame_done);
endinterface

// File: rtl/seg7_scan_display.sv
// Four-digit multiplexed 7-segment driver with tear-free frame updates,
// leading-zero blanking and registered outputs.
module seg7_scan_display #(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic   clk,
  input  logic   clr,
  seg7_if.slave  bus
);
  localparam int            CW   = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] PMAX = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic [15:0]   r_shown, r_pend;
  logic          r_pflag;
  logic [3:0]    r_dig;
  logic [7:0]    r_seg;
  logic          r_fd;

  logic       w_tick, w_wrap, w_lz, w_dp;
  logic [3:0] w_nib, w_dig;
  logic [6:0] w_hex;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40; 4'h1: hex7 = 7'h79; 4'h2: hex7 = 7'h24; 4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19; 4'h5: hex7 = 7'h12; 4'h6: hex7 = 7'h02; 4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00; 4'h9: hex7 = 7'h10; 4'hA: hex7 = 7'h08; 4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46; 4'hD: hex7 = 7'h21; 4'hE: hex7 = 7'h06; default: hex7 = 7'h0E;
    endcase
  endfunction

  assign w_tick = (r_presc == PMAX);
  assign w_wrap = w_tick && (r_idx == 2'd3);

  // w_lz: this digit and everything left of it is zero; rightmost never blanks
  always_comb begin
    w_nib = r_shown[3:0];
    w_dig = 4'b1110;
    w_lz  = 1'b0;
    w_dp  = bus.dp_in[0];
    case (r_idx)
      2'd0: begin w_nib = r_shown[15:12]; w_dig = 4'b0111; w_lz = (r_shown[15:12] == 4'h0); w_dp = bus.dp_in[3]; end
      2'd1: begin w_nib = r_shown[11:8];  w_dig = 4'b1011; w_lz = (r_shown[15:8]  == 8'h00); w_dp = bus.dp_in[2]; end
      2'd2: begin w_nib = r_shown[7:4];   w_dig = 4'b1101; w_lz = (r_shown[15:4]  == 12'h000); w_dp = bus.dp_in[1]; end
      default: ;
    endcase
    w_hex = (BLANK_LZ && w_lz) ? 7'h7F : hex7(w_nib);
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_presc <= '0;
      r_idx   <= 2'd0;
      r_shown <= 16'h0000;
      r_pend  <= 16'h0000;
      r_pflag <= 1'b0;
      r_dig   <= 4'b1111;
      r_seg   <= 8'hFF;
      r_fd    <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) r_idx <= r_idx + 2'd1;
      // shown only moves at the frame boundary; a same-cycle load bypasses pending
      if (w_wrap) begin
        if (bus.load)     r_shown <= bus.data;
        else if (r_pflag) r_shown <= r_pend;
        r_pflag <= 1'b0;
      end else if (bus.load) begin
        r_pend  <= bus.data;
        r_pflag <= 1'b1;
      end
      r_dig <= w_dig;
      r_seg <= {~w_dp, w_hex};
      r_fd  <= w_wrap;
    end
  end

  assign bus.dig_sel    = r_dig;
  assign bus.seg        = r_seg;
  assign bus.frame_done = r_fd;
endmodule
